// File: rtl/ifft_frame_mux_if.sv
// Handshake and data bundle for the IFFT frame multiplexer.
// master = the side that feeds the channels and drains out_*, slave = the mux itself.
interface ifft_frame_mux_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) ();
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, sel_err
  );
endinterface

// File: rtl/ifft_frame_mux.sv
// Registered N-to-1 frame multiplexer for the IFFT datapath.
// A channel is locked for a whole frame of FRAME_LEN samples; samples pass
// through a single output register with valid/ready handshaking and the
// final sample of each frame is flagged with out_last.
module ifft_frame_mux #(
  parameter int WIDTH     = 16,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int FRAME_LEN = 16
) (
  input logic             clk,
  input logic             rst,
  ifft_frame_mux_if.slave bus
);

  localparam int                 CNT_W      = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [SEL_W:0]     NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   cur_sel;
  logic [CNT_W-1:0]   beat_cnt;

  logic [WIDTH-1:0]   chan [NUM_IN];
  logic               sel_ok;
  logic               start;
  logic               load_ok;
  logic               xfer;
  logic               last_beat;

  logic [NUM_IN-1:0]  ready_vec;
  logic               busy_c;

  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic               last_q;
  logic               err_q;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign chan[k] = bus.in_data[k*WIDTH +: WIDTH];
  end

  // sel is widened by one bit so the range check also works when 2**SEL_W == NUM_IN
  assign sel_ok    = {1'b0, bus.sel} < NUM_IN_EXT;
  assign start     = (state == IDLE) && sel_ok && bus.in_valid[bus.sel];
  assign load_ok   = !valid_q || bus.out_ready;
  assign xfer      = (state == STREAM) && bus.in_valid[cur_sel] && load_ok;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // State register: IDLE waits for a valid request, STREAM carries one frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: lock on a valid request, release after the last beat is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)             state_nxt = STREAM;
      STREAM:  if (xfer && last_beat) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // State outputs: only the locked channel may see ready, and only when the register can load.
  always_comb begin
    ready_vec = '0;
    busy_c    = 1'b0;
    if (state == STREAM) begin
      ready_vec[cur_sel] = load_ok;
      busy_c             = 1'b1;
    end
  end

  // Datapath: channel lock, beat counter, output register and select-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel  <= '0;
      beat_cnt <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && !sel_ok;
      if (start) begin
        cur_sel  <= bus.sel;
        beat_cnt <= '0;
      end
      if (xfer) begin
        data_q   <= chan[cur_sel];
        valid_q  <= 1'b1;
        last_q   <= last_beat;
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.busy      = busy_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.sel_err   = err_q;

endmodule

// File: doc/ifft_frame_mux.md
# ifft_frame_mux

Parametrised, registered N-to-1 frame multiplexer for the IFFT input/output datapath of the NB-IoT LTE transmitter. Selects one of NUM_IN fixed-point sample streams, latches the selection for a whole IFFT frame so the channel never switches mid-symbol, and forwards samples through a one-stage output register with valid/ready handshaking. It marks the last sample of every frame. It replaces the combinational 2:1 16-bit IFFT mux, adding channel count, width, and frame-length parameters.

## Interface
Parameters:
- WIDTH, 16, sample width in bits (signed fixed-point, passed through untouched)
- NUM_IN, 4, number of input channels (>= 2)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
- FRAME_LEN, 16, samples per frame (IFFT points, >= 2); counter width is $clog2(FRAME_LEN)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_IN*WIDTH  packed channel data; channel k at [k*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel valid
- in_ready  out  NUM_IN  per-channel ready; at most one bit high at any time
- sel  in  SEL_W  channel request; sampled only in IDLE
- out_data  out  WIDTH  registered selected sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_last  out  1  qualifies the final sample of a frame (valid only with out_valid)
- busy  out  1  high while a frame is in progress (state STREAM)
- sel_err  out  1  one-cycle pulse: out-of-range sel sampled in IDLE

## Operation
- States: IDLE, STREAM.
- IDLE: in_ready = 0. Each cycle, sample sel:
  - If sel >= NUM_IN: pulse sel_err for one cycle and stay in IDLE.
  - Else, if in_valid[sel] = 1: latch cur_sel = sel, clear beat_cnt to 0, and go to STREAM.
  - Else: stay in IDLE.
- STREAM: in_ready[cur_sel] = !out_valid || out_ready; all other in_ready bits are 0. sel is ignored.
- Input transfer occurs when in_valid[cur_sel] && in_ready[cur_sel].
- On each input transfer:
  - out_data <= channel cur_sel data
  - out_valid <= 1
  - out_last <= (beat_cnt == FRAME_LEN-1)
  - beat_cnt increments
- On the transfer with beat_cnt == FRAME_LEN-1: beat_cnt wraps to 0 and the state returns to IDLE.
- Output register:
  - out_valid && out_ready with no new input transfer: out_valid <= 0, out_last <= 0.
  - out_valid && !out_ready: out_data and out_last hold; in_ready is low.
  - Simultaneous output drain and input transfer: the register reloads in the same cycle, giving full throughput.
- A gap in in_valid mid-frame only stalls the frame; there is no timeout, and the frame ends only after FRAME_LEN transfers.
- Data is not modified. Width in equals width out, with no sign extension or rounding.

## Timing
- Reset values: out_data = 0, out_valid = 0, out_last = 0, in_ready = 0, busy = 0, sel_err = 0, state = IDLE, beat_cnt = 0, cur_sel = 0.
- Reset mid-frame: the partial frame is dropped and the output register is cleared the next cycle. The next frame restarts at beat 0.
- Start-up: sel is sampled with in_valid high at cycle t; busy and in_ready are high from t+1.
- Latency: a sample accepted at cycle t appears on out_data with out_valid at t+1.
- With out_ready held high, a FRAME_LEN frame occupies in_ready for FRAME_LEN consecutive cycles. out_last accompanies the FRAME_LEN-th output.
- Frame turnaround: IDLE is entered the cycle after the last input transfer, and new sel is sampled in that cycle. This gives a minimum of one dead input cycle between frames, while the output side stays gap-free for the last beat.
- Back-pressure: in_ready reacts combinationally to out_ready within the same cycle; out_* change only on clock edges.

## Test plan
- Reset then idle: rst high 2 cycles, all in_valid = 0 -> all outputs 0, busy = 0, and in_ready = 0 forever.
- Single frame, defaults: sel = 2; channel 2 sends 0x0001..0x0010 continuously; out_ready = 1 -> in_ready = 4'b0100 for 16 cycles; out_data = 0x0001..0x0010 on consecutive cycles, one cycle after acceptance; out_last only with 0x0010; busy drops after the 16th accept.
- Switch lock: sel changes 2 -> 0 at beat 5 of a frame -> the frame still completes on channel 2; the next frame starts on channel 0 with a one-cycle input gap.
- Back-pressure: out_ready = 0 for cycles 3..6 of a frame -> out_data holds beat 3 value; in_ready[2] = 0 for those cycles; no sample lost or duplicated; 16 outputs total.
- Bad select (NUM_IN = 3): sel = 3 with in_valid = 3'b111 -> sel_err pulses once per IDLE cycle; no transfer occurs; busy stays 0.
- Mid-frame reset: rst asserted after beat 7 -> out_valid = 0 next cycle; the following frame's first output has out_last = 0 and its 16th output has out_last = 1.
